// File: rtl/prog_seq_detect_ctrl.sv
// Programmable serial pattern detector with arm/abort/complete handshake.
// Matches the low cfg_len bits of an 8-bit history against a latched pattern and counts hits.
module prog_seq_detect_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_pattern,
  input  logic [3:0] cfg_len,
  input  logic [3:0] cfg_max_hits,
  input  logic       bit_valid,
  input  logic       new_bit,
  input  logic       abort,
  input  logic       done_ack,
  output logic       detected,
  output logic [3:0] hit_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pat_q, pat_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  max_q, max_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  fill_q, fill_d;
  logic [3:0]  hit_q, hit_d;
  logic        det_q, det_d;

  logic [7:0]  shifted;
  logic [3:0]  fill_inc;
  logic [3:0]  hit_inc;
  logic [7:0]  mask;
  logic        match;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) begin
      return 4'd1;
    end else if (len > 4'd8) begin
      return 4'd8;
    end else begin
      return len;
    end
  endfunction

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [8:0] m;
    m = (9'd1 << len) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Match is judged on the history as it will look after this bit is accepted.
  always_comb begin
    shifted  = {shift_q[6:0], new_bit};
    fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    hit_inc  = sat_inc(hit_q);
    mask     = len_mask(len_q);
    match    = (fill_inc >= len_q) && ((shifted & mask) == (pat_q & mask));
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    max_d   = max_q;
    shift_d = shift_q;
    fill_d  = fill_q;
    hit_d   = hit_q;
    det_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          pat_d   = cfg_pattern;
          len_d   = clamp_len(cfg_len);
          max_d   = cfg_max_hits;
          shift_d = 8'd0;
          fill_d  = 4'd0;
          hit_d   = 4'd0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // Abort wins over a bit arriving in the same cycle, so its match is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          shift_d = shifted;
          fill_d  = fill_inc;
          if (match) begin
            det_d = 1'b1;
            hit_d = hit_inc;
            if ((max_q != 4'd0) && (hit_inc == max_q)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= 8'd0;
      len_q   <= 4'd0;
      max_q   <= 4'd0;
      shift_q <= 8'd0;
      fill_q  <= 4'd0;
      hit_q   <= 4'd0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      max_q   <= max_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      det_q   <= det_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_ARMED);
  assign done      = (state_q == S_DONE);
  assign detected  = det_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_prog_seq_detect_ctrl.sv
// Directed self-checking bench for prog_seq_detect_ctrl.
module tb_prog_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic [3:0] cfg_max_hits = 4'd0;
  logic       bit_valid = 1'b0;
  logic       new_bit = 1'b0;
  logic       abort = 1'b0;
  logic       done_ack = 1'b0;
  logic       detected;
  logic [3:0] hit_count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  prog_seq_detect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_max_hits (cfg_max_hits),
    .bit_valid    (bit_valid),
    .new_bit      (new_bit),
    .abort        (abort),
    .done_ack     (done_ack),
    .detected     (detected),
    .hit_count    (hit_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] mx);
    cfg_valid    = 1'b1;
    cfg_pattern  = pat;
    cfg_len      = len;
    cfg_max_hits = mx;
    cycle();
    cfg_valid    = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    new_bit   = b;
    cycle();
    bit_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({cfg_ready, busy, done, detected, hit_count} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/busy/done/det/hit=%b required 10000000",
               {cfg_ready, busy, done, detected, hit_count});
    end
  endtask

  task automatic test_single_match();
    logic [5:0] bits;
    bits = 6'b110011;
    configure(8'h33, 4'd6, 4'd1);
    n_checks++;
    if ({cfg_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_armed: got rdy/busy=%b required 01", {cfg_ready, busy});
    end
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[5-i]);
      n_checks++;
      if (detected !== (i == 5)) begin
        n_fail++;
        $display("FAIL single_det[%0d]: got %b required %b", i, detected, (i == 5));
      end
    end
    n_checks++;
    if ({hit_count, done, busy} !== 6'b0001_10) begin
      n_fail++;
      $display("FAIL single_done: got hit=%0d done=%b busy=%b required 1 1 0", hit_count, done, busy);
    end
    cycle();
    n_checks++;
    if (detected !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse_width: got %b required 0", detected);
    end
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;
    n_checks++;
    if ({cfg_ready, done, hit_count} !== 6'b10_0001) begin
      n_fail++;
      $display("FAIL single_ack: got rdy=%b done=%b hit=%0d required 1 0 1", cfg_ready, done, hit_count);
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits;
    logic [5:0] exp_det;
    bits    = 6'b101010;
    exp_det = 6'b000101;
    configure(8'h0A, 4'd4, 4'd0);
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[5-i]);
      n_checks++;
      if (detected !== exp_det[5-i]) begin
        n_fail++;
        $display("FAIL overlap_det[%0d]: got %b required %b", i, detected, exp_det[5-i]);
      end
    end
    done_ack = 1'b1;
    cfg_valid = 1'b1;
    cycle();
    done_ack = 1'b0;
    cfg_valid = 1'b0;
    n_checks++;
    if ({hit_count, busy, cfg_ready, done} !== 7'b0010_100) begin
      n_fail++;
      $display("FAIL overlap_armed: got hit=%0d busy=%b rdy=%b done=%b required 2 1 0 0",
               hit_count, busy, cfg_ready, done);
    end
    do_abort();
    n_checks++;
    if ({cfg_ready, busy, hit_count} !== 6'b10_0010) begin
      n_fail++;
      $display("FAIL overlap_abort: got rdy=%b busy=%b hit=%0d required 1 0 2", cfg_ready, busy, hit_count);
    end
  endtask

  task automatic test_fill_guard();
    configure(8'h00, 4'd3, 4'd0);
    send_bit(1'b0);
    n_checks++;
    if (detected !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_guard_1: got %b required 0", detected);
    end
    send_bit(1'b0);
    n_checks++;
    if (detected !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_guard_2: got %b required 0", detected);
    end
    send_bit(1'b0);
    n_checks++;
    if ({detected, hit_count} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL fill_guard_3: got det=%b hit=%0d required 1 1", detected, hit_count);
    end
    do_abort();
  endtask

  task automatic test_gaps();
    logic [6:0] vld;
    logic [6:0] exp_det;
    logic [3:0] exp_hit [7];
    vld     = 7'b1010101;
    exp_det = 7'b0010101;
    exp_hit = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    configure(8'h03, 4'd2, 4'd3);
    for (int i = 0; i < 7; i++) begin
      bit_valid = vld[6-i];
      new_bit   = vld[6-i];
      cycle();
      bit_valid = 1'b0;
      new_bit   = 1'b0;
      n_checks++;
      if ({detected, hit_count} !== {exp_det[6-i], exp_hit[i]}) begin
        n_fail++;
        $display("FAIL gaps_step[%0d]: got det=%b hit=%0d required %b %0d",
                 i, detected, hit_count, exp_det[6-i], exp_hit[i]);
      end
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL gaps_done: got done=%b busy=%b required 1 0", done, busy);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if ({detected, hit_count, done} !== 6'b0_0011_1) begin
      n_fail++;
      $display("FAIL gaps_ignore: got det=%b hit=%0d done=%b required 0 3 1", detected, hit_count, done);
    end
    do_abort();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_abort_in_done: got done=%b required 1", done);
    end
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;
    n_checks++;
    if ({cfg_ready, done, hit_count} !== 6'b10_0011) begin
      n_fail++;
      $display("FAIL gaps_ack: got rdy=%b done=%b hit=%0d required 1 0 3", cfg_ready, done, hit_count);
    end
  endtask

  task automatic test_abort_match();
    configure(8'h05, 4'd3, 4'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    abort     = 1'b1;
    bit_valid = 1'b1;
    new_bit   = 1'b1;
    cycle();
    abort     = 1'b0;
    bit_valid = 1'b0;
    n_checks++;
    if ({detected, hit_count, cfg_ready, busy} !== 7'b0_0000_10) begin
      n_fail++;
      $display("FAIL abort_match: got det=%b hit=%0d rdy=%b busy=%b required 0 0 1 0",
               detected, hit_count, cfg_ready, busy);
    end
    configure(8'h01, 4'd0, 4'd0);
    send_bit(1'b1);
    n_checks++;
    if ({detected, hit_count} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL len0_hit1: got det=%b hit=%0d required 1 1", detected, hit_count);
    end
    send_bit(1'b0);
    n_checks++;
    if (detected !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_miss: got %b required 0", detected);
    end
    send_bit(1'b1);
    n_checks++;
    if ({detected, hit_count} !== 5'b1_0010) begin
      n_fail++;
      $display("FAIL len0_hit2: got det=%b hit=%0d required 1 2", detected, hit_count);
    end
    do_abort();
  endtask

  task automatic test_len_clamp();
    configure(8'hFF, 4'd15, 4'd0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (detected !== (i == 7)) begin
        n_fail++;
        $display("FAIL len15_det[%0d]: got %b required %b", i, detected, (i == 7));
      end
    end
    do_abort();
  endtask

  task automatic test_saturate();
    configure(8'h01, 4'd1, 4'd0);
    for (int i = 0; i < 17; i++) send_bit(1'b1);
    n_checks++;
    if ({detected, hit_count, busy} !== 6'b1_1111_1) begin
      n_fail++;
      $display("FAIL hit_saturate: got det=%b hit=%0d busy=%b required 1 15 1", detected, hit_count, busy);
    end
    do_abort();
    configure(8'h00, 4'd1, 4'd0);
    n_checks++;
    if (hit_count !== 4'd0) begin
      n_fail++;
      $display("FAIL cfg_clears_hit: got %0d required 0", hit_count);
    end
    do_abort();
  endtask

  task automatic test_reset_armed();
    configure(8'h03, 4'd2, 4'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++;
    if (hit_count !== 4'd2) begin
      n_fail++;
      $display("FAIL rst_pre_hit: got %0d required 2", hit_count);
    end
    rst       = 1'b1;
    bit_valid = 1'b1;
    new_bit   = 1'b1;
    cycle();
    rst       = 1'b0;
    bit_valid = 1'b0;
    n_checks++;
    if ({cfg_ready, busy, done, detected, hit_count} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL rst_armed: got rdy/busy/done/det/hit=%b required 10000000",
               {cfg_ready, busy, done, detected, hit_count});
    end
    configure(8'h01, 4'd1, 4'd1);
    send_bit(1'b1);
    configure(8'h00, 4'd3, 4'd0);
    n_checks++;
    if ({done, cfg_ready, busy, hit_count} !== 7'b100_0001) begin
      n_fail++;
      $display("FAIL cfg_in_done: got done=%b rdy=%b busy=%b hit=%0d required 1 0 0 1",
               done, cfg_ready, busy, hit_count);
    end
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;
    n_checks++;
    if ({cfg_ready, hit_count} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL rst_final_ack: got rdy=%b hit=%0d required 1 1", cfg_ready, hit_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_overlap();
    test_fill_guard();
    test_gaps();
    test_abort_match();
    test_len_clamp();
    test_saturate();
    test_reset_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
